// File: rtl/bcd_countdown_99.sv
// rtl/bcd_countdown_99.sv - two-digit BCD down counter 99..00 with load, tc and seven-segment outputs; optional BLANK_LEADING_ZERO_EN
module bcd_countdown_99 #(
  parameter logic [3:0] RESET_TENS = 4'd9,
  parameter logic [3:0] RESET_ONES = 4'd9,
  parameter bit         WRAP       = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [3:0] i_load_tens,
  input  logic [3:0] i_load_ones,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic [0:6] o_seg_tens,
  output logic [0:6] o_seg_ones,
  output logic       o_zero,
  output logic       o_tc,
  output logic       o_load_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_tc;
  logic       r_load_err;

  logic [3:0] w_ld_tens;
  logic [3:0] w_ld_ones;
  logic       w_ld_bad;
  logic       w_ld_zero;
  logic [3:0] w_dec_tens;
  logic [3:0] w_dec_ones;
  logic       w_at_zero;
  logic       w_dec_to_zero;

  // a..g patterns, segment a in bit 0
  function automatic logic [0:6] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1111110;
      4'd1:    f_seg = 7'b0110000;
      4'd2:    f_seg = 7'b1101101;
      4'd3:    f_seg = 7'b1111001;
      4'd4:    f_seg = 7'b0110011;
      4'd5:    f_seg = 7'b1011011;
      4'd6:    f_seg = 7'b1011111;
      4'd7:    f_seg = 7'b1110000;
      4'd8:    f_seg = 7'b1111111;
      4'd9:    f_seg = 7'b1111011;
      default: f_seg = 7'b0000000;
    endcase
  endfunction

  // Out-of-range load digits are clamped to 9 so the digits never leave 0-9
  assign w_ld_tens     = (i_load_tens > 4'd9) ? 4'd9 : i_load_tens;
  assign w_ld_ones     = (i_load_ones > 4'd9) ? 4'd9 : i_load_ones;
  assign w_ld_bad      = (i_load_tens > 4'd9) || (i_load_ones > 4'd9);
  assign w_ld_zero     = (w_ld_tens == 4'd0) && (w_ld_ones == 4'd0);
  assign w_at_zero     = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_dec_to_zero = (r_tens == 4'd0) && (r_ones == 4'd1);

  // Next value for one decrement step, with borrow and optional 00 -> 99 wrap
  always_comb begin
    w_dec_tens = r_tens;
    w_dec_ones = r_ones;
    if (r_ones != 4'd0) begin
      w_dec_ones = r_ones - 4'd1;
    end else if (r_tens != 4'd0) begin
      w_dec_ones = 4'd9;
      w_dec_tens = r_tens - 4'd1;
    end else if (WRAP) begin
      w_dec_ones = 4'd9;
      w_dec_tens = 4'd9;
    end
  end

  // Control FSM and digit registers; load beats enable, EXPIRED holds until load
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_tens     <= RESET_TENS;
      r_ones     <= RESET_ONES;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (i_load) begin
        r_tens     <= w_ld_tens;
        r_ones     <= w_ld_ones;
        r_load_err <= w_ld_bad;
        if (!i_en)
          r_state <= S_IDLE;
        else if (!WRAP && w_ld_zero)
          r_state <= S_EXPIRED;
        else
          r_state <= S_COUNT;
      end else if (r_state == S_EXPIRED) begin
        r_state <= S_EXPIRED;
      end else if (i_en) begin
        r_tens <= w_dec_tens;
        r_ones <= w_dec_ones;
        r_tc   <= w_dec_to_zero;
        if (!WRAP && (w_dec_to_zero || w_at_zero))
          r_state <= S_EXPIRED;
        else
          r_state <= S_COUNT;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign o_tens     = r_tens;
  assign o_ones     = r_ones;
  assign o_zero     = w_at_zero;
  assign o_tc       = r_tc;
  assign o_load_err = r_load_err;
  assign o_seg_ones = f_seg(r_ones);
`ifdef BLANK_LEADING_ZERO_EN
  assign o_seg_tens = (r_tens == 4'd0) ? 7'b0000000 : f_seg(r_tens);
`else
  assign o_seg_tens = f_seg(r_tens);
`endif

endmodule

// File: tb/tb_bcd_countdown_99.sv
// tb/tb_bcd_countdown_99.sv - self-checking bench for bcd_countdown_99 (wrap and stop variants)
module tb_bcd_countdown_99;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] lt;
  logic [3:0] lo;

  logic [3:0] w_tens, w_ones, s_tens, s_ones;
  logic [0:6] w_segt, w_sego, s_segt, s_sego;
  logic       w_zero, w_tc, w_err, s_zero, s_tc, s_err;

  int n_checks = 0;
  int n_errors = 0;

  bcd_countdown_99 #(.RESET_TENS(4'd9), .RESET_ONES(4'd9), .WRAP(1'b1)) u_wrap (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_load(load),
    .i_load_tens(lt), .i_load_ones(lo),
    .o_tens(w_tens), .o_ones(w_ones), .o_seg_tens(w_segt), .o_seg_ones(w_sego),
    .o_zero(w_zero), .o_tc(w_tc), .o_load_err(w_err)
  );

  bcd_countdown_99 #(.RESET_TENS(4'd9), .RESET_ONES(4'd9), .WRAP(1'b0)) u_stop (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_load(load),
    .i_load_tens(lt), .i_load_ones(lo),
    .o_tens(s_tens), .o_ones(s_ones), .o_seg_tens(s_segt), .o_seg_ones(s_sego),
    .o_zero(s_zero), .o_tc(s_tc), .o_load_err(s_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference seven-segment patterns, a..g left to right
  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: ref_seg = 7'b1111110;
      1: ref_seg = 7'b0110000;
      2: ref_seg = 7'b1101101;
      3: ref_seg = 7'b1111001;
      4: ref_seg = 7'b0110011;
      5: ref_seg = 7'b1011011;
      6: ref_seg = 7'b1011111;
      7: ref_seg = 7'b1110000;
      8: ref_seg = 7'b1111111;
      9: ref_seg = 7'b1111011;
      default: ref_seg = 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg_tens(input int d);
`ifdef BLANK_LEADING_ZERO_EN
    ref_seg_tens = (d == 0) ? 7'b0000000 : ref_seg(d);
`else
    ref_seg_tens = ref_seg(d);
`endif
  endfunction

  function automatic int clamp9(input logic [3:0] d);
    clamp9 = (d > 4'd9) ? 9 : int'(d);
  endfunction

  // Model: each counter is a plain integer 0..99
  int   m_vw, m_vs;
  logic m_tcw, m_tcs, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vw  <= 99;
      m_vs  <= 99;
      m_tcw <= 1'b0;
      m_tcs <= 1'b0;
      m_err <= 1'b0;
    end else begin
      m_tcw <= 1'b0;
      m_tcs <= 1'b0;
      m_err <= 1'b0;
      if (load) begin
        m_vw  <= clamp9(lt) * 10 + clamp9(lo);
        m_vs  <= clamp9(lt) * 10 + clamp9(lo);
        m_err <= (lt > 4'd9) || (lo > 4'd9);
      end else if (en) begin
        m_tcw <= (m_vw == 1);
        m_vw  <= (m_vw == 0) ? 99 : m_vw - 1;
        m_tcs <= (m_vs == 1);
        m_vs  <= (m_vs == 0) ? 0 : m_vs - 1;
      end
    end
  end

  task automatic cmp_dut(input string tag, input int v, input logic tcm,
                         input logic [3:0] tens, input logic [3:0] ones,
                         input logic [0:6] segt, input logic [0:6] sego,
                         input logic zero, input logic tc, input logic err);
    chk({tag, ".tens"}, 32'(tens), 32'(v / 10));
    chk({tag, ".ones"}, 32'(ones), 32'(v % 10));
    chk({tag, ".seg_tens"}, 32'(segt), 32'(ref_seg_tens(v / 10)));
    chk({tag, ".seg_ones"}, 32'(sego), 32'(ref_seg(v % 10)));
    chk({tag, ".zero"}, 32'(zero), 32'(v == 0));
    chk({tag, ".tc"}, 32'(tc), 32'(tcm));
    chk({tag, ".load_err"}, 32'(err), 32'(m_err));
  endtask

  logic run_cmp = 1'b0;

  // Every-cycle comparison of both counters against the model
  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      cmp_dut("wrap", m_vw, m_tcw, w_tens, w_ones, w_segt, w_sego, w_zero, w_tc, w_err);
      cmp_dut("stop", m_vs, m_tcs, s_tens, s_ones, s_segt, s_sego, s_zero, s_tc, s_err);
    end
  end

  // Apply inputs for one edge, return at posedge + 1
  task automatic tick(input logic l, input logic [3:0] t, input logic [3:0] o, input logic e);
    load = l;
    lt   = t;
    lo   = o;
    en   = e;
    @(posedge clk);
    #1;
  endtask

  int tc_w_cnt;
  int tc_s_cnt;
  int en_pat[4];
  int exp_pat[4];

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    lt   = 4'd0;
    lo   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.tens", 32'(w_tens), 32'd9);
    chk("reset.ones", 32'(w_ones), 32'd9);
    chk("reset.zero", 32'(w_zero), 32'd0);
    chk("reset.tc", 32'(w_tc), 32'd0);
    chk("reset.seg_ones", 32'(w_sego), 32'(7'b1111011));
    rst = 1'b0;
    run_cmp = 1'b1;

    // Load 12 and count down 12 edges to 00
    tick(1'b1, 4'd1, 4'd2, 1'b0);
    chk("load12.value", 32'(w_tens * 10 + w_ones), 32'd12);
    tc_w_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 4'd0, 4'd0, 1'b1);
      tc_w_cnt += int'(w_tc);
    end
    chk("cnt12.tens", 32'(w_tens), 32'd0);
    chk("cnt12.ones", 32'(w_ones), 32'd0);
    chk("cnt12.zero", 32'(w_zero), 32'd1);
    chk("cnt12.tc", 32'(w_tc), 32'd1);
    chk("cnt12.stop_tc", 32'(s_tc), 32'd1);
    chk("cnt12.tc_count", 32'(tc_w_cnt), 32'd1);
    tick(1'b0, 4'd0, 4'd0, 1'b0);
    chk("cnt12.tc_drop", 32'(w_tc), 32'd0);

    // 00 with en: wrap goes to 99, stop holds 00 for 5 edges
    tc_s_cnt = 0;
    tick(1'b0, 4'd0, 4'd0, 1'b1);
    chk("wrap.value", 32'(w_tens * 10 + w_ones), 32'd99);
    chk("wrap.tc", 32'(w_tc), 32'd0);
    tc_s_cnt += int'(s_tc);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'd0, 4'd0, 1'b1);
      tc_s_cnt += int'(s_tc);
    end
    chk("stop.hold", 32'(s_tens * 10 + s_ones), 32'd0);
    chk("stop.tc_count", 32'(tc_s_cnt), 32'd0);

    // Load beats enable; clamping of out-of-range digits
    tick(1'b1, 4'd4, 4'd5, 1'b1);
    chk("load45.value", 32'(w_tens * 10 + w_ones), 32'd45);
    chk("load45.stop_value", 32'(s_tens * 10 + s_ones), 32'd45);
    chk("load45.err", 32'(w_err), 32'd0);
    tick(1'b1, 4'd12, 4'd3, 1'b0);
    chk("load93.value", 32'(w_tens * 10 + w_ones), 32'd93);
    chk("load93.err", 32'(w_err), 32'd1);
    tick(1'b0, 4'd0, 4'd0, 1'b0);
    chk("load93.err_drop", 32'(w_err), 32'd0);
    chk("load93.hold", 32'(w_tens * 10 + w_ones), 32'd93);
    tick(1'b1, 4'd5, 4'd15, 1'b0);
    chk("load59.value", 32'(w_tens * 10 + w_ones), 32'd59);
    chk("load59.err", 32'(w_err), 32'd1);
    tick(1'b1, 4'd15, 4'd15, 1'b0);
    chk("load99.value", 32'(w_tens * 10 + w_ones), 32'd99);

    // Enable pattern 1,0,0,1 from 20
    tick(1'b1, 4'd2, 4'd0, 1'b0);
    en_pat  = '{1, 0, 0, 1};
    exp_pat = '{19, 19, 19, 18};
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'd0, 4'd0, en_pat[i][0]);
      chk($sformatf("enpat[%0d]", i), 32'(w_tens * 10 + w_ones), 32'(exp_pat[i]));
    end

    // 10 -> 09 borrow and segment decode
    tick(1'b1, 4'd1, 4'd0, 1'b0);
    chk("seg10.tens", 32'(w_segt), 32'(7'b0110000));
    tick(1'b0, 4'd0, 4'd0, 1'b1);
    chk("borrow.tens", 32'(w_tens), 32'd0);
    chk("borrow.ones", 32'(w_ones), 32'd9);
    chk("seg09.ones", 32'(w_sego), 32'(7'b1111011));
`ifdef BLANK_LEADING_ZERO_EN
    chk("seg09.tens", 32'(w_segt), 32'(7'b0000000));
`else
    chk("seg09.tens", 32'(w_segt), 32'(7'b1111110));
`endif

    // Load of 00 with en: zero, no tc; stop variant expires
    tick(1'b1, 4'd0, 4'd0, 1'b1);
    chk("load00.zero", 32'(w_zero), 32'd1);
    chk("load00.tc", 32'(w_tc), 32'd0);
    chk("load00.stop_tc", 32'(s_tc), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
    chk("expired.hold", 32'(s_tens * 10 + s_ones), 32'd0);
    tick(1'b1, 4'd0, 4'd3, 1'b1);
    chk("load03.value", 32'(s_tens * 10 + s_ones), 32'd3);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
    chk("from03.stop_value", 32'(s_tens * 10 + s_ones), 32'd0);
    chk("from03.stop_tc", 32'(s_tc), 32'd1);
    chk("from03.wrap_tc", 32'(w_tc), 32'd1);

    // Full wrap cycle: next tc exactly 100 enabled edges later
    tc_w_cnt = 0;
    tc_s_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 4'd0, 4'd0, 1'b1);
      tc_w_cnt += int'(w_tc);
      tc_s_cnt += int'(s_tc);
    end
    chk("wrap100.tc_count", 32'(tc_w_cnt), 32'd1);
    chk("wrap100.last_tc", 32'(w_tc), 32'd1);
    chk("wrap100.stop_tc_count", 32'(tc_s_cnt), 32'd0);

    // Asynchronous reset mid-count
    tick(1'b1, 4'd4, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'd0, 4'd0, 1'b1);
    chk("precount.value", 32'(w_tens * 10 + w_ones), 32'd42);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset.tens", 32'(w_tens), 32'd9);
    chk("midreset.ones", 32'(w_ones), 32'd9);
    chk("midreset.tc", 32'(w_tc), 32'd0);
    chk("midreset.zero", 32'(w_zero), 32'd0);
    chk("midreset.seg_ones", 32'(w_sego), 32'(7'b1111011));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b0, 4'd0, 4'd0, 1'b1);
    chk("postreset.value", 32'(w_tens * 10 + w_ones), 32'd98);
    tick(1'b0, 4'd0, 4'd0, 1'b0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
